// File: rtl/prio_arb_pkg.sv
// rtl/prio_arb_pkg.sv - shared state encoding and parameter defaults for the priority round-robin arbiter
package prio_arb_pkg;

  localparam int DEF_N     = 4;
  localparam int DEF_PW    = 3;
  localparam int DEF_AGE_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/prio_arb_pick.sv
// rtl/prio_arb_pick.sv - combinational winner selection by effective priority with round-robin tie break
module prio_arb_pick
  import prio_arb_pkg::*;
#(
  parameter  int N  = DEF_N,
  parameter  int EW = DEF_PW + 1,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [N*EW-1:0] eprio,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   winner,
  output logic            found
);

  int            w_idx;
  logic [EW-1:0] w_best;
  logic [EW-1:0] w_cur;

  // Scan upward from ptr; strict '>' keeps the first tied index met in scan order.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    w_best = '0;
    w_cur  = '0;
    w_idx  = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = int'(ptr) + k;
      if (w_idx >= N) begin
        w_idx = w_idx - N;
      end
      w_cur = eprio[w_idx*EW +: EW];
      if (req[w_idx] && (!found || (w_cur > w_best))) begin
        found  = 1'b1;
        w_best = w_cur;
        winner = w_idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/prio_rr_arb.sv
// rtl/prio_rr_arb.sv - priority arbiter with aging, round-robin ties and hold-until-release grants
module prio_rr_arb
  import prio_arb_pkg::*;
#(
  parameter  int N     = DEF_N,
  parameter  int PW    = DEF_PW,
  parameter  int AGE_W = DEF_AGE_W,
  localparam int IW    = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*PW-1:0] prio,
  input  logic            rel,
  output logic [N-1:0]    gnt,
  output logic [IW-1:0]   gnt_id,
  output logic            busy
);

  localparam int                EW        = PW + 1;
  localparam logic [AGE_W-1:0]  AGE_MAX   = '1;
  localparam logic [EW-1:0]     AGED_PRIO = {1'b1, {PW{1'b0}}};
  localparam logic [N-1:0]      ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};

  state_e                  r_state;
  logic [IW-1:0]           r_ptr;
  logic [N-1:0][AGE_W-1:0] r_age;
  logic [N-1:0]            r_gnt;
  logic [IW-1:0]           r_gnt_id;
  logic                    r_busy;

  logic [N*EW-1:0] w_eprio;
  logic [IW-1:0]   w_winner;
  logic            w_found;
  logic            w_release;
  logic            w_arbitrate;
  logic [IW-1:0]   w_next_ptr;

  // A starved requester (age saturated) outranks every programmable priority.
  always_comb begin
    w_eprio = '0;
    for (int i = 0; i < N; i++) begin
      w_eprio[i*EW +: EW] = (r_age[i] == AGE_MAX) ? AGED_PRIO : {1'b0, prio[i*PW +: PW]};
    end
  end

  prio_arb_pick #(
    .N  (N),
    .EW (EW)
  ) u_pick (
    .req    (req),
    .eprio  (w_eprio),
    .ptr    (r_ptr),
    .winner (w_winner),
    .found  (w_found)
  );

  assign w_release   = rel || !req[r_gnt_id];
  assign w_arbitrate = (r_state == IDLE) && w_found;
  assign w_next_ptr  = (w_winner == IW'(N - 1)) ? '0 : w_winner + 1'b1;

  // Grant FSM: arbitrate only from IDLE, so every grant is followed by at least one IDLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_busy   <= 1'b0;
      r_ptr    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state  <= GRANT;
            r_gnt    <= ONE_HOT0 << w_winner;
            r_gnt_id <= w_winner;
            r_busy   <= 1'b1;
            r_ptr    <= w_next_ptr;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Age counters move only at arbitration: winner and idle requesters clear, waiting losers count up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_age <= '0;
    end else if (w_arbitrate) begin
      for (int i = 0; i < N; i++) begin
        if (IW'(i) == w_winner) begin
          r_age[i] <= '0;
        end else if (req[i]) begin
          r_age[i] <= (r_age[i] == AGE_MAX) ? AGE_MAX : r_age[i] + 1'b1;
        end else begin
          r_age[i] <= '0;
        end
      end
    end
  end

  assign gnt    = r_gnt;
  assign gnt_id = r_gnt_id;
  assign busy   = r_busy;

endmodule

// File: tb/tb_prio_rr_arb.sv
// tb/tb_prio_rr_arb.sv - directed self-checking bench for prio_rr_arb
module tb_prio_rr_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [11:0] prio;
  logic        rel;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic        busy;

  int n_checks;
  int n_pass;

  prio_rr_arb #(
    .N     (4),
    .PW    (3),
    .AGE_W (2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .prio   (prio),
    .rel    (rel),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    rel   = 1'b0;
    prio  = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    prio  = '0;
    rel   = 1'b0;
    #3;
    n_checks++;
    if ({gnt, gnt_id, busy} !== 7'b0) $display("FAIL reset_state: gnt=%b gnt_id=%0d busy=%b required 0000/0/0", gnt, gnt_id, busy);
    else n_pass++;
    tick();
    n_checks++;
    if ({gnt, busy} !== 5'b0) $display("FAIL reset_held: gnt=%b busy=%b required 0000/0", gnt, busy);
    else n_pass++;
    req = '0;
    rst_n = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({gnt, busy} !== 5'b0) $display("FAIL idle_no_req: gnt=%b busy=%b required 0000/0", gnt, busy);
    else n_pass++;
  endtask

  task automatic test_priority();
    do_reset();
    prio = {3'd0, 3'd5, 3'd0, 3'd2};
    req  = 4'b0101;
    tick();
    n_checks++;
    if ({gnt, gnt_id, busy} !== {4'b0100, 2'd2, 1'b1}) $display("FAIL highest_prio: gnt=%b gnt_id=%0d busy=%b required 0100/2/1", gnt, gnt_id, busy);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    prio = {3'd3, 3'd3, 3'd3, 3'd3};
    req  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if ({gnt, busy} !== {exp_gnt[k], 1'b1}) $display("FAIL rr_grant%0d: gnt=%b busy=%b required %b/1", k, gnt, busy, exp_gnt[k]);
      else n_pass++;
      rel = 1'b1;
      tick();
      rel = 1'b0;
      n_checks++;
      if ({gnt, busy} !== 5'b0) $display("FAIL rr_idle%0d: gnt=%b busy=%b required 0000/0", k, gnt, busy);
      else n_pass++;
    end
  endtask

  task automatic test_aging();
    logic [3:0] exp_gnt [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0010};
    do_reset();
    prio = {3'd0, 3'd0, 3'd7, 3'd1};
    req  = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (gnt !== exp_gnt[k]) $display("FAIL aging_arb%0d: gnt=%b required %b", k, gnt, exp_gnt[k]);
      else n_pass++;
      rel = 1'b1;
      tick();
      rel = 1'b0;
    end
  endtask

  task automatic test_hold_release();
    do_reset();
    prio = {3'd7, 3'd0, 3'd0, 3'd1};
    req  = 4'b1001;
    rel  = 1'b1;
    tick();
    rel  = 1'b0;
    n_checks++;
    if ({gnt, gnt_id, busy} !== {4'b1000, 2'd3, 1'b1}) $display("FAIL rel_in_idle: gnt=%b gnt_id=%0d busy=%b required 1000/3/1", gnt, gnt_id, busy);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      req[0] = ~req[0];
      tick();
      n_checks++;
      if (gnt !== 4'b1000) $display("FAIL hold%0d: gnt=%b required 1000", k, gnt);
      else n_pass++;
    end
    req[0] = 1'b1;
    rel = 1'b1;
    tick();
    rel = 1'b0;
    n_checks++;
    if ({gnt, busy} !== 5'b0) $display("FAIL after_rel: gnt=%b busy=%b required 0000/0", gnt, busy);
    else n_pass++;
    tick();
    n_checks++;
    if ({gnt, busy} !== {4'b1000, 1'b1}) $display("FAIL regrant: gnt=%b busy=%b required 1000/1", gnt, busy);
    else n_pass++;
  endtask

  task automatic test_drop();
    do_reset();
    prio = {3'd0, 3'd4, 3'd5, 3'd0};
    req  = 4'b0110;
    tick();
    n_checks++;
    if ({gnt, gnt_id} !== {4'b0010, 2'd1}) $display("FAIL drop_first: gnt=%b gnt_id=%0d required 0010/1", gnt, gnt_id);
    else n_pass++;
    prio = {3'd0, 3'd7, 3'd0, 3'd0};
    tick();
    n_checks++;
    if (gnt !== 4'b0010) $display("FAIL prio_ignored: gnt=%b required 0010", gnt);
    else n_pass++;
    req = 4'b0100;
    tick();
    n_checks++;
    if ({gnt, busy} !== 5'b0) $display("FAIL owner_drop: gnt=%b busy=%b required 0000/0", gnt, busy);
    else n_pass++;
    tick();
    n_checks++;
    if ({gnt, gnt_id} !== {4'b0100, 2'd2}) $display("FAIL after_drop: gnt=%b gnt_id=%0d required 0100/2", gnt, gnt_id);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    prio = {3'd3, 3'd3, 3'd3, 3'd3};
    req  = 4'b1111;
    tick();
    rel = 1'b1;
    tick();
    rel = 1'b0;
    tick();
    n_checks++;
    if (gnt !== 4'b0010) $display("FAIL pre_reset_grant: gnt=%b required 0010", gnt);
    else n_pass++;
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({gnt, busy} !== 5'b0) $display("FAIL async_reset: gnt=%b busy=%b required 0000/0", gnt, busy);
    else n_pass++;
    #2;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({gnt, gnt_id, busy} !== {4'b0001, 2'd0, 1'b1}) $display("FAIL post_reset_grant: gnt=%b gnt_id=%0d busy=%b required 0001/0/1", gnt, gnt_id, busy);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    if (rst_n && ($countones(gnt) > 1)) begin
      n_checks++;
      $display("FAIL onehot: gnt=%b required at most one bit", gnt);
    end
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    req      = '0;
    prio     = '0;
    rel      = 1'b0;
    test_reset();
    test_priority();
    test_round_robin();
    test_aging();
    test_hold_release();
    test_drop();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
